// File: rtl/hls_seq_pkg.sv
// Shared types for the Bambu accelerator run sequencer: FSM state encoding and slave access size.
package hls_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StRdReq,
        StRdWait,
        StRdOut,
        StFin
    } seq_state_e;

    // Byte-wide access as encoded on S_data_ram_size.
    localparam logic [3:0] SZ_BYTE = 4'd8;

endpackage

// File: rtl/hls_slave_port_if.sv
// Single-outstanding access engine for slave RAM channel 0; channel 1 is tied off.
module hls_slave_port_if
    import hls_seq_pkg::*;
#(
    parameter int unsigned AddrW = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [AddrW-1:0]   addr_i,
    input  logic [7:0]         wdata_i,
    output logic               busy_o,
    output logic               ack_o,
    output logic [7:0]         rdata_o,
    output logic [1:0]         s_oe_ram_o,
    output logic [1:0]         s_we_ram_o,
    output logic [2*AddrW-1:0] s_addr_ram_o,
    output logic [15:0]        s_wdata_ram_o,
    output logic [7:0]         s_data_ram_size_o,
    input  logic [15:0]        sout_rdata_ram_i,
    input  logic [1:0]         sout_datardy_i
);

    logic             pending_q, pending_d;
    logic             oe_q, oe_d;
    logic             we_q, we_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             unused_hi;

    assign unused_hi = ^{sout_rdata_ram_i[15:8], sout_datardy_i[1]};

    always_comb begin
        pending_d = pending_q;
        oe_d      = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        // Completion only counts while an access is in flight, so a stale DataRdy is dropped.
        ack_o     = pending_q & sout_datardy_i[0];
        if (ack_o) begin
            pending_d = 1'b0;
        end
        if (req_i && !pending_q) begin
            pending_d = 1'b1;
            oe_d      = ~we_i;
            we_d      = we_i;
            addr_d    = addr_i;
            if (we_i) begin
                wdata_d = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy_o            = pending_q;
    assign rdata_o           = sout_rdata_ram_i[7:0];
    assign s_oe_ram_o        = {1'b0, oe_q};
    assign s_we_ram_o        = {1'b0, we_q};
    assign s_addr_ram_o      = {{AddrW{1'b0}}, addr_q};
    assign s_wdata_ram_o     = {8'h00, wdata_q};
    assign s_data_ram_size_o = {4'h0, (oe_q | we_q) ? SZ_BYTE : 4'h0};

endmodule

// File: rtl/hls_run_sequencer.sv
// Runs one accelerator job: load image, pulse start, time the run, read results back, report.
module hls_run_sequencer
    import hls_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned LOAD_BYTES = 64,
    parameter int unsigned LOAD_BASE  = 0,
    parameter int unsigned RD_BYTES   = 64,
    parameter int unsigned RD_BASE    = 0,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_go,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                status_valid,
    output logic                status_ok,
    output logic [CNT_W-1:0]    cycles,
    output logic                acc_start_port,
    input  logic                acc_done_port,
    output logic [1:0]          S_oe_ram,
    output logic [1:0]          S_we_ram,
    output logic [2*ADDR_W-1:0] S_addr_ram,
    output logic [15:0]         S_Wdata_ram,
    output logic [7:0]          S_data_ram_size,
    input  logic [15:0]         Sout_Rdata_ram,
    input  logic [1:0]          Sout_DataRdy
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    seq_state_e        state_q, state_d;
    logic [31:0]       idx_q, idx_d;
    logic [31:0]       ridx_q, ridx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              ok_q, ok_d;
    logic [7:0]        rdata_q, rdata_d;

    logic              port_req, port_we, port_busy, port_ack;
    logic [ADDR_W-1:0] port_addr;
    logic [7:0]        port_wdata, port_rdata;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        ridx_d         = ridx_q;
        cnt_d          = cnt_q;
        cycles_d       = cycles_q;
        ok_d           = ok_q;
        rdata_d        = rdata_q;
        port_req       = 1'b0;
        port_we        = 1'b0;
        port_addr      = ADDR_W'(RD_BASE + ridx_q);
        port_wdata     = in_data;
        in_ready       = 1'b0;
        acc_start_port = 1'b0;
        out_valid      = 1'b0;
        status_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_go) begin
                    idx_d    = '0;
                    ridx_d   = '0;
                    cnt_d    = '0;
                    cycles_d = '0;
                    ok_d     = 1'b0;
                    state_d  = (LOAD_BYTES == 0) ? StStart : StLoad;
                end
            end
            StLoad: begin
                in_ready  = ~port_busy;
                port_we   = 1'b1;
                port_addr = ADDR_W'(LOAD_BASE + idx_q);
                port_req  = in_valid & ~port_busy;
                if (port_ack) begin
                    if (idx_q == LOAD_BYTES - 1) begin
                        state_d = StStart;
                    end else begin
                        idx_d = idx_q + 32'd1;
                    end
                end
            end
            StStart: begin
                acc_start_port = 1'b1;
                cnt_d          = CNT_W'(1);
                state_d        = StRun;
            end
            StRun: begin
                // done wins over timeout when both land on the same cycle.
                if (acc_done_port) begin
                    cycles_d = cnt_q;
                    ok_d     = 1'b1;
                    ridx_d   = '0;
                    state_d  = (RD_BYTES == 0) ? StFin : StRdReq;
                end else if (cnt_q == TimeoutCnt) begin
                    cycles_d = TimeoutCnt;
                    ok_d     = 1'b0;
                    state_d  = StFin;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRdReq: begin
                port_req = 1'b1;
                state_d  = StRdWait;
            end
            StRdWait: begin
                if (port_ack) begin
                    rdata_d = port_rdata;
                    state_d = StRdOut;
                end
            end
            StRdOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (ridx_q == RD_BYTES - 1) begin
                        state_d = StFin;
                    end else begin
                        ridx_d  = ridx_q + 32'd1;
                        state_d = StRdReq;
                    end
                end
            end
            StFin: begin
                status_valid = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            ridx_q   <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            ok_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ridx_q   <= ridx_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            ok_q     <= ok_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign status_ok = ok_q;
    assign cycles    = cycles_q;
    assign out_data  = rdata_q;

    hls_slave_port_if #(
        .AddrW (ADDR_W)
    ) u_port (
        .clk_i             (clock),
        .rst_i             (reset),
        .req_i             (port_req),
        .we_i              (port_we),
        .addr_i            (port_addr),
        .wdata_i           (port_wdata),
        .busy_o            (port_busy),
        .ack_o             (port_ack),
        .rdata_o           (port_rdata),
        .s_oe_ram_o        (S_oe_ram),
        .s_we_ram_o        (S_we_ram),
        .s_addr_ram_o      (S_addr_ram),
        .s_wdata_ram_o     (S_Wdata_ram),
        .s_data_ram_size_o (S_data_ram_size),
        .sout_rdata_ram_i  (Sout_Rdata_ram),
        .sout_datardy_i    (Sout_DataRdy)
    );

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Bench for hls_run_sequencer: slave memory model, accelerator model and read-back scoreboard.
module tb_hls_run_sequencer;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned LOAD_BYTES = 4;
    localparam int unsigned LOAD_BASE  = 0;
    localparam int unsigned RD_BYTES   = 3;
    localparam int unsigned RD_BASE    = 127;
    localparam int unsigned TIMEOUT    = 20;
    localparam int unsigned CNT_W      = 32;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_go = 1'b0;
    logic                busy;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [7:0]          in_data = 8'h00;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [7:0]          out_data;
    logic                status_valid;
    logic                status_ok;
    logic [CNT_W-1:0]    cycles;
    logic                acc_start_port;
    logic                acc_done_port = 1'b0;
    logic [1:0]          S_oe_ram;
    logic [1:0]          S_we_ram;
    logic [2*ADDR_W-1:0] S_addr_ram;
    logic [15:0]         S_Wdata_ram;
    logic [7:0]          S_data_ram_size;
    logic [15:0]         Sout_Rdata_ram = 16'h3CAD;
    logic [1:0]          Sout_DataRdy = 2'b00;

    always #5 clock = ~clock;

    hls_run_sequencer #(
        .ADDR_W     (ADDR_W),
        .LOAD_BYTES (LOAD_BYTES),
        .LOAD_BASE  (LOAD_BASE),
        .RD_BYTES   (RD_BYTES),
        .RD_BASE    (RD_BASE),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_go          (cmd_go),
        .busy            (busy),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .status_valid    (status_valid),
        .status_ok       (status_ok),
        .cycles          (cycles),
        .acc_start_port  (acc_start_port),
        .acc_done_port   (acc_done_port),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] load_data [4] = '{8'h5A, 8'hFF, 8'h11, 8'h22};
    logic [7:0] exp_rd    [3] = '{8'hA5, 8'h5A, 8'hFF};

    // Slave memory model: completion two cycles after each oe/we pulse.
    logic [7:0] mem [128];
    logic [7:0] wr_addr_log [$];
    logic [7:0] wr_data_log [$];
    logic [7:0] rd_addr_log [$];
    int         rdy_cnt = 0;
    logic [7:0] rdy_data = 8'h00;
    bit         wr_out = 1'b0;
    int         viol = 0;

    always @(negedge clock) begin
        Sout_DataRdy   = 2'b00;
        Sout_Rdata_ram = 16'h3CAD;
        if (wr_out && in_ready) viol++;
        if (S_oe_ram[0] && S_we_ram[0]) viol++;
        if (S_oe_ram[1] || S_we_ram[1] || S_addr_ram[13:7] != 0 || S_Wdata_ram[15:8] != 0) viol++;
        if ((S_oe_ram[0] || S_we_ram[0]) != (S_data_ram_size == 8'h08)) viol++;
        if (!(S_oe_ram[0] || S_we_ram[0]) && S_data_ram_size != 8'h00) viol++;
        if (rdy_cnt == 1) begin
            Sout_DataRdy   = 2'b01;
            Sout_Rdata_ram = {8'hC3, rdy_data};
            wr_out         = 1'b0;
        end
        if (rdy_cnt > 0) rdy_cnt--;
        if (S_we_ram[0]) begin
            mem[S_addr_ram[6:0]] = S_Wdata_ram[7:0];
            wr_addr_log.push_back({1'b0, S_addr_ram[6:0]});
            wr_data_log.push_back(S_Wdata_ram[7:0]);
            rdy_data = 8'h00;
            rdy_cnt  = 2;
            wr_out   = 1'b1;
        end
        if (S_oe_ram[0]) begin
            rd_addr_log.push_back({1'b0, S_addr_ram[6:0]});
            rdy_data = mem[S_addr_ram[6:0]];
            rdy_cnt  = 2;
        end
    end

    int n_starts = 0;
    always @(negedge clock) if (acc_start_port) n_starts++;

    // Downstream consumer: stalls each byte 5 cycles, checks stability and order.
    logic [7:0] sb_q [$];
    int         stall = 0;
    logic [7:0] held = 8'h00;
    int         stable_err = 0;

    always @(negedge clock) begin
        if (reset) begin
            out_ready = 1'b0;
            stall     = 0;
        end else if (out_ready) begin
            out_ready = 1'b0;
        end else if (out_valid) begin
            if (stall == 0) held = out_data;
            else if (out_data !== held) stable_err++;
            stall++;
            if (stall == 6) begin
                out_ready = 1'b1;
                stall     = 0;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got byte %02h, expected no output", out_data);
                end else begin
                    check("rd_byte", {56'd0, out_data}, {56'd0, sb_q.pop_front()});
                end
            end
        end
    end

    task automatic load_bytes();
        bit ok;
        for (int i = 0; i < int'(LOAD_BYTES); i++) begin
            ok       = 1'b0;
            in_valid = 1'b1;
            in_data  = load_data[i];
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clock);
                ok = in_ready;
            end
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL load_accept: byte %0d never accepted, expected in_ready", i);
                break;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic accel(input int d, input int lim, input bit go_mid, output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clock);
            seen = acc_start_port;
        end
        if (seen) begin
            acc_done_port = (d == 0);
            for (int c = 1; c <= lim; c++) begin
                @(posedge clock);
                #1;
                acc_done_port = (c == d);
                cmd_go        = go_mid && (c == 3);
            end
            @(posedge clock);
            #1;
            acc_done_port = 1'b0;
            cmd_go        = 1'b0;
        end
    endtask

    task automatic wait_status(output bit got, output bit pulse1, output logic sok,
                               output logic [CNT_W-1:0] scyc);
        got = 1'b0; pulse1 = 1'b0; sok = 1'b0; scyc = '0;
        for (int t = 0; t < 1000 && !got; t++) begin
            @(negedge clock);
            if (status_valid) begin
                got  = 1'b1;
                sok  = status_ok;
                scyc = cycles;
            end
        end
        if (got) begin
            @(negedge clock);
            pulse1 = !status_valid;
        end
    endtask

    task automatic pulse_go();
        @(posedge clock);
        #1 cmd_go = 1'b1;
        @(posedge clock);
        #1 cmd_go = 1'b0;
    endtask

    task automatic do_run(input int d, input bit exp_ok, input int exp_cyc, input bit go_mid);
        bit got, pulse1, seen;
        logic sok;
        logic [CNT_W-1:0] scyc;
        wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
        n_starts = 0; viol = 0; stable_err = 0;
        if (exp_ok) for (int i = 0; i < int'(RD_BYTES); i++) sb_q.push_back(exp_rd[i]);
        pulse_go();
        check("busy_after_go", busy, 1);
        check("status_cleared", {status_ok, cycles}, 0);
        fork
            load_bytes();
            accel(d, 25, go_mid, seen);
            wait_status(got, pulse1, sok, scyc);
        join
        check("start_seen", seen, 1);
        check("status_seen", got, 1);
        check("status_pulse_1cyc", pulse1, 1);
        check("status_ok", sok, exp_ok);
        check("cycles", scyc, exp_cyc);
        check("start_pulses", n_starts, 1);
        check("wr_count", wr_addr_log.size(), LOAD_BYTES);
        if (wr_addr_log.size() == int'(LOAD_BYTES)) begin
            for (int i = 0; i < int'(LOAD_BYTES); i++) begin
                check("wr_addr", wr_addr_log[i], (LOAD_BASE + i) % 128);
                check("wr_data", wr_data_log[i], load_data[i]);
            end
        end
        check("rd_count", rd_addr_log.size(), exp_ok ? RD_BYTES : 0);
        if (exp_ok && rd_addr_log.size() == int'(RD_BYTES)) begin
            for (int i = 0; i < int'(RD_BYTES); i++)
                check("rd_addr", rd_addr_log[i], (RD_BASE + i) % 128);
        end
        check("rd_all_consumed", sb_q.size(), 0);
        check("bus_protocol", viol, 0);
        check("out_stable", stable_err, 0);
        check("idle_after_run", busy, 0);
    endtask

    function automatic bit outs_nonzero();
        return ({busy, in_ready, out_valid, out_data, status_valid, status_ok, cycles,
                 acc_start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
                 S_data_ram_size} !== '0);
    endfunction

    task automatic recover();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        in_valid = 1'b0; acc_done_port = 1'b0; cmd_go = 1'b0;
        sb_q.delete();
        repeat (6) @(posedge clock);
        #1;
    endtask

    typedef struct {
        int d;
        bit ok;
        int cyc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit got, seen;
        vecs[0] = '{10, 1'b1, 10};   // nominal
        vecs[1] = '{1, 1'b1, 1};     // done in first RUN cycle
        vecs[2] = '{20, 1'b1, 20};   // done on the timeout cycle wins
        vecs[3] = '{0, 1'b0, 20};    // done during START is ignored
        vecs[4] = '{255, 1'b0, 20};  // never done

        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[127] = 8'hA5;

        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs_zero", outs_nonzero(), 0);
        reset = 1'b0;
        @(posedge clock);
        #1 acc_done_port = 1'b1;
        @(posedge clock);
        #1 acc_done_port = 1'b0;
        @(negedge clock);
        check("idle_ignores_done", {busy, status_valid, in_ready}, 0);

        for (int v = 0; v < 5; v++) do_run(vecs[v].d, vecs[v].ok, vecs[v].cyc, 1'b0);

        // Reset while a write pulse is on the bus.
        pulse_go();
        in_valid = 1'b1;
        in_data  = load_data[0];
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clock);
            got = in_ready;
        end
        check("rstA_accept", got, 1);
        @(posedge clock);
        #1;
        check("rstA_we_before", S_we_ram[0], 1);
        reset = 1'b1;
        #1;
        check("rstA_outputs_zero", outs_nonzero(), 0);
        recover();

        // Reset in RUN.
        pulse_go();
        load_bytes();
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clock);
            seen = acc_start_port;
        end
        check("rstB_start", seen, 1);
        repeat (3) @(posedge clock);
        #1;
        check("rstB_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("rstB_outputs_zero", outs_nonzero(), 0);
        recover();
        do_run(10, 1'b1, 10, 1'b0);

        // Reset in RD_WAIT with a read completion still pending in the memory.
        pulse_go();
        load_bytes();
        accel(5, 5, 1'b0, seen);
        check("rstC_start", seen, 1);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clock);
            got = S_oe_ram[0];
        end
        check("rstC_oe", got, 1);
        @(posedge clock);
        #1;
        check("rstC_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("rstC_outputs_zero", outs_nonzero(), 0);
        recover();
        check("rstC_stale_rdy_ignored", {busy, out_valid, status_valid}, 0);

        // Clean run with a cmd_go injected mid-RUN.
        do_run(10, 1'b1, 10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
